// File: rtl/mmio_bus.sv
// rtl/mmio_bus.sv - MIPS data-memory port: word RAM plus I/O window (switches, hex, LEDs, buttons, cycle counter).
// Optional MMIO_DEBOUNCE_EN builds per-button debounce counters; otherwise levels follow the synchroniser.
module mmio_bus #(
   parameter int          DMEM_WORDS      = 1024,
   parameter logic [31:0] IO_BASE         = 32'h400,
   parameter int          NUM_BTN         = 5,
   parameter int          SW_W            = 16,
   parameter int          OUT_W           = 16,
   parameter int          DEBOUNCE_CYCLES = 65536
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               memwrite,
   input  logic               memread,
   input  logic [31:0]        addr,
   input  logic [31:0]        writedata,
   output logic [31:0]        readdata,
   input  logic [NUM_BTN-1:0] btn,
   input  logic [SW_W-1:0]    sw,
   output logic [OUT_W-1:0]   hex,
   output logic [OUT_W-1:0]   led
);
   localparam int AW = $clog2(DMEM_WORDS);

   logic [31:0]        mem [DMEM_WORDS];
   logic               is_io;
   logic [2:0]         off;
   logic               wr_io;
   logic               rd_clr;

   logic [OUT_W-1:0]   hex_q, hex_d, led_q, led_d;
   logic [SW_W-1:0]    sw_s1_q, sw_s2_q;
   logic [NUM_BTN-1:0] btn_s1_q, btn_s2_q;
   logic [NUM_BTN-1:0] lvl_q, lvl_d, evt_q, evt_d;
   logic [31:0]        cyc_q, cyc_d;

   assign is_io  = (addr[31:5] == IO_BASE[31:5]);
   assign off    = addr[4:2];
   assign wr_io  = memwrite && is_io;
   // A write that also carries memread is a write only.
   assign rd_clr = memread && !memwrite && is_io && (off == 3'd3);

   always_ff @(posedge clk) begin
      if (memwrite && !is_io)
         mem[addr[AW+1:2]] <= writedata;
   end

   always_comb begin
      readdata = '0;
      if (is_io) begin
         case (off)
            3'd0:    readdata = 32'(hex_q);
            3'd1:    readdata = 32'(sw_s2_q);
            3'd2:    readdata = 32'(lvl_q);
            3'd3:    readdata = 32'(evt_q);
            3'd4:    readdata = 32'(led_q);
            3'd5:    readdata = cyc_q;
            default: readdata = '0;
         endcase
      end else begin
         readdata = mem[addr[AW+1:2]];
      end
   end

   always_comb begin
      hex_d = hex_q;
      led_d = led_q;
      cyc_d = cyc_q + 32'd1;
      if (wr_io && off == 3'd0) hex_d = writedata[OUT_W-1:0];
      if (wr_io && off == 3'd4) led_d = writedata[OUT_W-1:0];
      if (wr_io && off == 3'd5) cyc_d = writedata;
   end

   // Rising-level set is OR-ed in last so it wins over any clear on the same edge.
   always_comb begin
      evt_d = evt_q;
      if (rd_clr)
         evt_d = '0;
      else if (wr_io && off == 3'd3)
         evt_d = evt_q & ~writedata[NUM_BTN-1:0];
      evt_d = evt_d | (lvl_d & ~lvl_q);
   end

`ifdef MMIO_DEBOUNCE_EN
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [CW-1:0] cnt_q [NUM_BTN];
   logic [CW-1:0] cnt_d [NUM_BTN];

   always_comb begin
      lvl_d = lvl_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         cnt_d[i] = cnt_q[i];
         if (btn_s2_q[i] == lvl_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            lvl_d[i] = btn_s2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
      end
   end
`else
   always_comb begin
      lvl_d = btn_s2_q;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hex_q    <= '0;
         led_q    <= '0;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         lvl_q    <= '0;
         evt_q    <= '0;
         cyc_q    <= '0;
      end else begin
         hex_q    <= hex_d;
         led_q    <= led_d;
         sw_s1_q  <= sw;
         sw_s2_q  <= sw_s1_q;
         btn_s1_q <= btn;
         btn_s2_q <= btn_s1_q;
         lvl_q    <= lvl_d;
         evt_q    <= evt_d;
         cyc_q    <= cyc_d;
      end
   end

   assign hex = hex_q;
   assign led = led_q;

   logic unused_ok;
   assign unused_ok = &{1'b0, addr[1:0], (DEBOUNCE_CYCLES > 1)};
endmodule
